encoder83_irq: RTL and testbench

//  Collects events on N request lines and reports them as a binary index.

---
 rtl/encoder83_irq_pkg.sv | 24 ++
 rtl/encoder83_irq_prio_enc83.sv | 13 +
 rtl/encoder83_irq.sv | 79 +++++++
 tb/tb_encoder83_irq.sv | 124 ++++++++++++
 4 files changed

// File: rtl/encoder83_irq_pkg.sv
// Shared widths and index helpers for the 8-line event encoder.
package encoder_pkg;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  // Lowest set bit index of vec; 0 when vec is empty.
  function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] vec);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/encoder83_irq_prio_enc83.sv
// Combinational lowest-index priority encoder over the pending vector.
module prio_enc83
  import encoder_pkg::*;
(
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  assign o_idx = lowest_idx(i_vec);
  assign o_any = |i_vec;

endmodule

// File: rtl/encoder83_irq.sv
// Latches request-line events into a pending register and presents the
// lowest pending index to a consumer through a valid/ack handshake.
module encoder83_irq
  import encoder_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_opt,
  input  logic         i_ack,
  input  logic         i_ovf_clr,
  output logic         o_valid,
  output logic [W-1:0] o_idx,
  output logic [N-1:0] o_pend,
  output logic         o_ovf
);

  logic [N-1:0] r_prev;
  logic         r_opt;
  logic         r_arm;

  logic [N-1:0] w_act;
  logic [N-1:0] w_set;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_pend_next;
  logic         w_accept;
  logic         w_ovf_set;
  logic [W-1:0] w_idx_next;
  logic         w_any_next;

  // Event detection is muted on the arming cycle and whenever polarity flips,
  // since either would otherwise show every active line as a fresh edge.
  always_comb begin
    w_act       = i_opt ? i_req : ~i_req;
    w_set       = '0;
    w_clr       = '0;
    w_accept    = o_valid & i_ack;
    w_ovf_set   = 1'b0;
    if (r_arm && (i_opt == r_opt)) begin
      w_set = EDGE ? (w_act & ~r_prev) : w_act;
    end
    if (w_accept) w_clr = onehot(o_idx);
    w_pend_next = (o_pend & ~w_clr) | w_set;
    if (EDGE) w_ovf_set = |(w_set & o_pend & ~w_clr);
  end

  prio_enc83 u_prio (
    .i_vec (w_pend_next),
    .o_idx (w_idx_next),
    .o_any (w_any_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev  <= '0;
      r_opt   <= i_opt;
      r_arm   <= 1'b0;
      o_pend  <= '0;
      o_valid <= 1'b0;
      o_idx   <= '0;
      o_ovf   <= 1'b0;
    end else begin
      r_prev <= w_act;
      r_opt  <= i_opt;
      r_arm  <= 1'b1;
      o_pend <= w_pend_next;
      // Presented index holds until consumed; no preemption by lower indices.
      if (!o_valid || w_accept) begin
        o_valid <= w_any_next;
        o_idx   <= w_idx_next;
      end
      if (w_ovf_set)      o_ovf <= 1'b1;
      else if (i_ovf_clr) o_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encoder83_irq.sv
// Directed scoreboard bench for encoder83_irq (N=8, EDGE=1).
module tb_encoder83_irq;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic [7:0] pend;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       opt;
  logic       ack;
  logic       ovf_clr;
  logic       valid;
  logic [2:0] idx;
  logic [7:0] pend;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  encoder83_irq #(.EDGE(1'b1)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_opt     (opt),
    .i_ack     (ack),
    .i_ovf_clr (ovf_clr),
    .o_valid   (valid),
    .o_idx     (idx),
    .o_pend    (pend),
    .o_ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outcome, compare after the edge.
  task automatic step(input string tag, input logic r, input logic [7:0] rq, input logic o,
                      input logic a, input logic oc, input logic ev, input logic [2:0] ei,
                      input logic [7:0] ep, input logic eo);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; opt = o; ack = a; ovf_clr = oc;
    q.push_back('{valid: ev, idx: ei, pend: ep, ovf: eo});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".valid"}, 8'(valid), 8'(e.valid));
    chk({tag, ".idx"},   8'(idx),   8'(e.idx));
    chk({tag, ".pend"},  pend,      e.pend);
    chk({tag, ".ovf"},   8'(ovf),   8'(e.ovf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = 8'h01; opt = 1'b1; ack = 1'b0; ovf_clr = 1'b0;
    //         tag      rst  req    opt  ack  oclr  v  idx  pend   ovf
    step("rst0",    1, 8'h01, 1, 0, 0,  0, 0, 8'h00, 0);
    step("rst1",    1, 8'h01, 1, 0, 0,  0, 0, 8'h00, 0);
    // 1: arming cycle swallows the held line
    step("t1arm",   0, 8'h01, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t1hold",  0, 8'h01, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t1low",   0, 8'h00, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t1rise",  0, 8'h01, 1, 0, 0,  1, 0, 8'h01, 0);
    step("t1ack",   0, 8'h01, 1, 1, 0,  0, 0, 8'h00, 0);
    // 2: two events drained back to back
    step("t2low",   0, 8'h00, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t2set",   0, 8'h24, 1, 0, 0,  1, 2, 8'h24, 0);
    step("t2ack2",  0, 8'h24, 1, 1, 0,  1, 5, 8'h20, 0);
    step("t2ack5",  0, 8'h24, 1, 1, 0,  0, 0, 8'h00, 0);
    // 3: lower index arrives without preempting
    step("t3low",   0, 8'h00, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t3b5",    0, 8'h20, 1, 0, 0,  1, 5, 8'h20, 0);
    step("t3b1",    0, 8'h22, 1, 0, 0,  1, 5, 8'h22, 0);
    step("t3ack5",  0, 8'h22, 1, 1, 0,  1, 1, 8'h02, 0);
    step("t3ack1",  0, 8'h22, 1, 1, 0,  0, 0, 8'h00, 0);
    // 4: overflow on re-edge of a pending line, then clear
    step("t4low",   0, 8'h00, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t4b3",    0, 8'h08, 1, 0, 0,  1, 3, 8'h08, 0);
    step("t4drop",  0, 8'h00, 1, 0, 0,  1, 3, 8'h08, 0);
    step("t4ovf",   0, 8'h08, 1, 0, 0,  1, 3, 8'h08, 1);
    step("t4oclr",  0, 8'h08, 1, 0, 1,  1, 3, 8'h08, 0);
    step("t4ack",   0, 8'h08, 1, 1, 0,  0, 0, 8'h00, 0);
    // 5: active-low lines and polarity toggles
    step("t5tog0",  0, 8'hFF, 0, 0, 0,  0, 0, 8'h00, 0);
    step("t5idle",  0, 8'hFF, 0, 0, 0,  0, 0, 8'h00, 0);
    step("t5b6",    0, 8'hBF, 0, 0, 0,  1, 6, 8'h40, 0);
    step("t5ack",   0, 8'hBF, 0, 1, 0,  0, 0, 8'h00, 0);
    step("t5tog1",  0, 8'hBF, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t5steady",0, 8'hBF, 1, 0, 0,  0, 0, 8'h00, 0);
    // 6: set beats clear on the same bit, then reset mid-drain
    step("t6low",   0, 8'h00, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t6b4",    0, 8'h10, 1, 0, 0,  1, 4, 8'h10, 0);
    step("t6drop",  0, 8'h00, 1, 0, 0,  1, 4, 8'h10, 0);
    step("t6race",  0, 8'h10, 1, 1, 0,  1, 4, 8'h10, 0);
    step("t6b0",    0, 8'h11, 1, 0, 0,  1, 4, 8'h11, 0);
    step("t6rst",   1, 8'h11, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t6arm",   0, 8'h11, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t6hold",  0, 8'h11, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t6ackidle",0,8'h11, 1, 1, 0,  0, 0, 8'h00, 0);
    step("t6rearm", 0, 8'h01, 1, 0, 0,  0, 0, 8'h00, 0);
    step("t6b4new", 0, 8'h11, 1, 0, 0,  1, 4, 8'h10, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
